// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift ops plus an
// iterative shift-add multiply, with registered result and status flags.
module alu_seq_core #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             of,
  output logic             err
);

  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             of;
    logic             err;
  } alu_out_t;

  function automatic alu_out_t alu_eval(input logic [3:0]       op_i,
                                        input logic [WIDTH-1:0] a_i,
                                        input logic [WIDTH-1:0] b_i);
    alu_out_t                o;
    logic signed [WIDTH-1:0] as_s;
    logic signed [WIDTH-1:0] bs_s;
    logic        [WIDTH:0]   sum;
    logic        [SHW-1:0]   sh;
    o    = '0;
    as_s = a_i;
    bs_s = b_i;
    sum  = '0;
    sh   = b_i[SHW-1:0];
    case (op_i)
      4'd0: o.res = a_i & b_i;
      4'd1: o.res = a_i | b_i;
      4'd2: o.res = a_i ^ b_i;
      4'd3: o.res = ~(a_i | b_i);
      4'd4: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        o.res = sum[WIDTH-1:0];
        o.cf  = sum[WIDTH];
        o.of  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (o.res[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd5: begin
        // Top bit of the widened difference is the unsigned borrow
        sum   = {1'b0, a_i} - {1'b0, b_i};
        o.res = sum[WIDTH-1:0];
        o.cf  = sum[WIDTH];
        o.of  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (o.res[WIDTH-1] != a_i[WIDTH-1]);
      end
      4'd6:  o.res[0] = (as_s < bs_s);
      4'd7:  o.res[0] = (a_i < b_i);
      4'd8:  o.res = a_i << sh;
      4'd9:  o.res = a_i >> sh;
      4'd10: o.res = as_s >>> sh;
      4'd11: o = '0;
      default: o.err = 1'b1;
    endcase
    return o;
  endfunction

  state_t             state;
  logic               vld_p1;
  logic [SHW-1:0]     cnt_p1;
  logic [2*WIDTH-1:0] mcand_p1;
  logic [WIDTH-1:0]   mplr_p1;
  logic [2*WIDTH-1:0] acc_p1;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               accept;
  alu_out_t           alu_c;

  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_p1;
  assign alu_c     = alu_eval(op, a, b);
  assign acc_nxt   = acc_p1 + (mplr_p1[0] ? mcand_p1 : '0);

  // Stage p0 -> p1: accept, single-cycle evaluation, multiply sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
      result <= '0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
      of     <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL) begin
              cnt_p1 <= '0;
              state  <= BUSY;
            end else begin
              result <= alu_c.res;
              zf     <= (alu_c.res == '0);
              nf     <= alu_c.res[WIDTH-1];
              cf     <= alu_c.cf;
              of     <= alu_c.of;
              err    <= alu_c.err;
              vld_p1 <= 1'b1;
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          cnt_p1 <= cnt_p1 + SHW'(1);
          if (cnt_p1 == SHW'(WIDTH - 1)) begin
            result <= acc_nxt[WIDTH-1:0];
            zf     <= (acc_nxt[WIDTH-1:0] == '0);
            nf     <= acc_nxt[WIDTH-1];
            cf     <= |acc_nxt[2*WIDTH-1:WIDTH];
            of     <= 1'b0;
            err    <= 1'b0;
            vld_p1 <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Multiply datapath: one multiplier bit consumed per BUSY cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p1 <= {{WIDTH{1'b0}}, a};
      mplr_p1  <= b;
      acc_p1   <= '0;
    end else if (state == BUSY) begin
      acc_p1   <= acc_nxt;
      mcand_p1 <= mcand_p1 << 1;
      mplr_p1  <= mplr_p1 >> 1;
    end
  end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked sequential ALU: the next generation of the team's combinational ALU. It has a configurable datapath width, a registered result with full status flags (zero, negative, carry, overflow), signed/unsigned compares, three shift types and an iterative multiply. It sits between the operand source (switch/register logic) and the result consumer (LED/display mux or writeback) and uses valid/ready handshakes on both sides.

## Interface

Parameters:

- WIDTH, 32, datapath width in bits (≥ 4, power of two).
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- zf  out  1  result == 0.
- nf  out  1  result[WIDTH-1].
- cf  out  1  carry/borrow/multiply-high (see Operation).
- of  out  1  signed overflow.
- err  out  1  illegal opcode was issued.

## Operation

- Opcodes:
  - 0 AND; 1 OR; 2 XOR; 3 NOR; 4 ADD; 5 SUB (a−b).
  - 6 SLT: signed a<b gives 1, else 0. 7 SLTU: unsigned.
  - 8 SLL: a << b[SHW-1:0]. 9 SRL: logical right. 10 SRA: arithmetic right.
  - 11 MUL: low WIDTH bits of unsigned a*b.
  - 12–15 illegal.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, go to DONE if op≠MUL, or to BUSY if op=MUL.
  - BUSY: iterative shift-add, one multiplier bit per cycle, WIDTH cycles, then DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Operands and op are captured at accept. Later changes on a/b/op have no effect until the next accept.
- Flags:
  - zf and nf are derived from the final result for every opcode.
  - ADD: cf = carry out; of = (a[MSB]==b[MSB]) && (result[MSB]≠a[MSB]).
  - SUB: cf = borrow (a<b unsigned); of = (a[MSB]≠b[MSB]) && (result[MSB]≠a[MSB]).
  - MUL: cf = 1 if the upper WIDTH bits of the full 2·WIDTH product are nonzero; of = 0.
  - All other opcodes: cf = of = 0.
- Shift amount uses only b[SHW-1:0]; upper bits of b are ignored.
- Illegal opcode: result=0, zf=1, nf=cf=of=0, err=1, latency as a single-cycle op. err=0 for legal opcodes.

## Timing

- Reset (rst=1 at an edge):
  - State becomes IDLE; result, zf, nf, cf, of, err, out_valid all become 0.
  - in_ready is 0 while rst=1 and 1 in the first cycle after rst deasserts.
- Accept: an operation is accepted at the edge where in_valid && in_ready.
- Latency from the accept edge:
  - Non-MUL: out_valid=1 after 1 edge.
  - MUL: out_valid=1 after WIDTH+1 edges.
- in_ready=0 in BUSY and DONE. At most one operation is in flight. Minimum issue interval is 2 cycles for non-MUL.
- In DONE, result and all flags stay stable while out_valid=1 && out_ready=0, for arbitrary stall length.
- Release happens at the edge with out_valid && out_ready. The FSM returns to IDLE, and in_ready=1 in the next cycle. There is no same-edge accept of a new operation.
- After release, out_valid drops to 0. result and flags keep their last values until the next completion.
- in_valid in BUSY or DONE is ignored. The source must hold its transaction until in_ready.
- Reset mid-MUL (BUSY) or in DONE: the operation is aborted, all reset values apply, and no out_valid is produced for it.

## Test plan

- ADD a=7FFFFFFF, b=00000001 → result 80000000, nf=1, of=1, cf=0, zf=0, out_valid one edge after accept.
- SUB a=00000000, b=00000001 → FFFFFFFF, cf=1, of=0, nf=1. Then SLT a=80000000, b=00000001 → 1; SLTU with the same operands → 0.
- SRA a=80000000, b=00000024 → shift amount 4, result F8000000. SRL with the same operands → 08000000.
- MUL a=00010000, b=00010000 → result 0, zf=1, cf=1, out_valid exactly 33 edges after accept, in_ready=0 throughout. MUL 3×0607 → 00001215, cf=0.
- Backpressure: hold out_ready=0 for 10 cycles after ADD 1+2 → result 3 and flags stable, in_ready=0, a second in_valid ignored. Then out_ready=1 → in_ready=1 the next cycle.
- Illegal op=13 → result 0, zf=1, err=1. Reset asserted at BUSY cycle 5 of a MUL → outputs 0, no out_valid, in_ready=1 the cycle after rst drops.
